// File: rtl/issue_unit_pkg.sv
// Shared core defines (REG_SIZE, WORD_SIZE, UNIT_SIZE, unit opcodes) plus the issue-stage package.
// Build option ISSUE_STATS_EN adds the stats ports on issue_unit.
`ifndef BOURGEOIS_DEFINES_SVH
`define BOURGEOIS_DEFINES_SVH
`ifndef REG_SIZE
`define REG_SIZE 5
`endif
`ifndef WORD_SIZE
`define WORD_SIZE 32
`endif
`ifndef UNIT_SIZE
`define UNIT_SIZE 3
`endif
`define UNIT_LW  3'b000
`define UNIT_SW  3'b001
`define UNIT_ADD 3'b010
`define UNIT_MUL 3'b011
`define UNIT_MV  3'b100
`endif

package issue_unit_pkg;
   localparam int unsigned REG_W  = `REG_SIZE;
   localparam int unsigned WORD_W = `WORD_SIZE;
   localparam int unsigned UNIT_W = `UNIT_SIZE;

   localparam logic [UNIT_W-1:0] UNIT_LW  = UNIT_W'(`UNIT_LW);
   localparam logic [UNIT_W-1:0] UNIT_SW  = UNIT_W'(`UNIT_SW);
   localparam logic [UNIT_W-1:0] UNIT_ADD = UNIT_W'(`UNIT_ADD);
   localparam logic [UNIT_W-1:0] UNIT_MUL = UNIT_W'(`UNIT_MUL);
   localparam logic [UNIT_W-1:0] UNIT_MV  = UNIT_W'(`UNIT_MV);

   typedef struct packed {
      logic [UNIT_W-1:0]        unit;
      logic [REG_W-1:0]         reg1;
      logic [REG_W-1:0]         reg2;
      logic [REG_W-1:0]         reg3;
      logic                     hasimm;
      logic signed [WORD_W-1:0] imm;
   } issue_entry_t;

   // Codes above MV have no execution unit behind them.
   function automatic logic unit_is_legal(input logic [UNIT_W-1:0] u);
      return (u <= UNIT_MV);
   endfunction
endpackage

// File: rtl/issue_fifo.sv
// In-order queue storage for issue_unit: circular buffer with wrapping pointers and an occupancy count.
module issue_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         i_push,
   input  logic                         i_pop,
   input  logic                         i_flush,
   input  logic [WIDTH-1:0]             i_data,
   output logic [WIDTH-1:0]             o_head_c,
   output logic [$clog2(DEPTH+1)-1:0]   o_count
);
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH+1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;

   // Pointers wrap by overflow since DEPTH is a power of two.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         o_count  <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         o_count  <= '0;
      end else begin
         if (i_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (i_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         if (i_push && !i_pop)      o_count <= o_count + CNT_W'(1);
         else if (i_pop && !i_push) o_count <= o_count - CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (i_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
   end

   assign o_head_c = r_mem[r_rd_ptr];
endmodule

// File: rtl/issue_unit.sv
// Issue stage: queues decoded instructions and strobes them into the RS entry port.
// Build option ISSUE_STATS_EN adds issued_cnt / stall_cnt outputs.
module issue_unit
   import issue_unit_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [UNIT_W-1:0]          in_unit,
   input  logic [REG_W-1:0]           in_reg1,
   input  logic [REG_W-1:0]           in_reg2,
   input  logic [REG_W-1:0]           in_reg3,
   input  logic                       in_hasimm,
   input  logic signed [WORD_W-1:0]   in_imm,
   input  logic                       rs_full,
   input  logic                       flush,
   output logic [UNIT_W-1:0]          unit,
   output logic [REG_W-1:0]           reg1,
   output logic [REG_W-1:0]           reg2,
   output logic [REG_W-1:0]           reg3,
   output logic                       hasimm,
   output logic signed [WORD_W-1:0]   imm,
   output logic                       enable,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       err
`ifdef ISSUE_STATS_EN
   ,
   output logic [31:0]                issued_cnt,
   output logic [31:0]                stall_cnt
`endif
);
   localparam int unsigned CNT_W = $clog2(DEPTH+1);

   localparam logic [1:0] ST_EMPTY  = 2'd0;
   localparam logic [1:0] ST_ACTIVE = 2'd1;
   localparam logic [1:0] ST_STALL  = 2'd2;

   logic [1:0]       r_state;
   logic [1:0]       w_state_nxt;
   issue_entry_t     w_in;
   issue_entry_t     w_head;
   logic             w_accept;
   logic             w_legal;
   logic             w_push;
   logic             w_pop;
   logic [CNT_W-1:0] w_cnt_nxt;

   assign in_ready  = (count != CNT_W'(DEPTH));
   assign w_legal   = unit_is_legal(in_unit);
   assign w_accept  = in_valid && in_ready && !flush;
   assign w_push    = w_accept && w_legal;
   // Non-empty state is equivalent to count != 0.
   assign w_pop     = (r_state != ST_EMPTY) && !rs_full && !flush;
   assign w_cnt_nxt = count + CNT_W'(w_push) - CNT_W'(w_pop);

   assign w_in.unit   = in_unit;
   assign w_in.reg1   = in_reg1;
   assign w_in.reg2   = in_reg2;
   assign w_in.reg3   = in_reg3;
   assign w_in.hasimm = in_hasimm;
   assign w_in.imm    = in_imm;

   issue_fifo #(
      .DEPTH (DEPTH),
      .WIDTH ($bits(issue_entry_t))
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .i_push   (w_push),
      .i_pop    (w_pop),
      .i_flush  (flush),
      .i_data   (w_in),
      .o_head_c (w_head),
      .o_count  (count)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_EMPTY;
      else     r_state <= w_state_nxt;
   end

   // Empty wins; otherwise the RS back-pressure seen at this edge picks ACTIVE or STALL.
   always_comb begin
      w_state_nxt = r_state;
      if (flush || (w_cnt_nxt == '0)) w_state_nxt = ST_EMPTY;
      else if (rs_full)               w_state_nxt = ST_STALL;
      else                            w_state_nxt = ST_ACTIVE;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         unit   <= '0;
         reg1   <= '0;
         reg2   <= '0;
         reg3   <= '0;
         hasimm <= 1'b0;
         imm    <= '0;
         enable <= 1'b0;
         err    <= 1'b0;
      end else begin
         enable <= w_pop;
         if (w_pop) begin
            unit   <= w_head.unit;
            reg1   <= w_head.reg1;
            reg2   <= w_head.reg2;
            reg3   <= w_head.reg3;
            hasimm <= w_head.hasimm;
            imm    <= w_head.imm;
         end
         if (w_accept && !w_legal) err <= 1'b1;
      end
   end

`ifdef ISSUE_STATS_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         issued_cnt <= '0;
         stall_cnt  <= '0;
      end else begin
         if (w_pop) issued_cnt <= issued_cnt + 32'd1;
         if ((r_state != ST_EMPTY) && rs_full) stall_cnt <= stall_cnt + 32'd1;
      end
   end
`endif
endmodule

// File: tb/tb_issue_unit.sv
// Randomized scoreboard bench for issue_unit against a queue-based reference model.
module tb_issue_unit;
   import issue_unit_pkg::*;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned CNT_W = $clog2(DEPTH+1);

   logic                     clk = 1'b0;
   logic                     rst = 1'b1;
   logic                     in_valid = 1'b0;
   logic                     in_ready;
   logic [UNIT_W-1:0]        in_unit = '0;
   logic [REG_W-1:0]         in_reg1 = '0;
   logic [REG_W-1:0]         in_reg2 = '0;
   logic [REG_W-1:0]         in_reg3 = '0;
   logic                     in_hasimm = 1'b0;
   logic signed [WORD_W-1:0] in_imm = '0;
   logic                     rs_full = 1'b0;
   logic                     flush = 1'b0;
   logic [UNIT_W-1:0]        unit;
   logic [REG_W-1:0]         reg1, reg2, reg3;
   logic                     hasimm;
   logic signed [WORD_W-1:0] imm;
   logic                     enable;
   logic [CNT_W-1:0]         count;
   logic                     err;
`ifdef ISSUE_STATS_EN
   logic [31:0]              issued_cnt, stall_cnt;
`endif

   issue_unit #(.DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_unit(in_unit), .in_reg1(in_reg1), .in_reg2(in_reg2), .in_reg3(in_reg3),
      .in_hasimm(in_hasimm), .in_imm(in_imm), .rs_full(rs_full), .flush(flush),
      .unit(unit), .reg1(reg1), .reg2(reg2), .reg3(reg3), .hasimm(hasimm), .imm(imm),
      .enable(enable), .count(count), .err(err)
`ifdef ISSUE_STATS_EN
      , .issued_cnt(issued_cnt), .stall_cnt(stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   // Reference model: the queue contents, what the RS should have seen, and sticky/stat state.
   issue_entry_t m_q[$];
   issue_entry_t exp_q[$];
   issue_entry_t m_last;
   issue_entry_t m_new;
   bit           m_en, m_err, m_pop, m_acc;
   int unsigned  m_issued, m_stall;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_q.delete();
         exp_q.delete();
         m_last   = '0;
         m_en     = 1'b0;
         m_err    = 1'b0;
         m_issued = 0;
         m_stall  = 0;
      end else begin
         m_acc = in_valid && (m_q.size() != DEPTH) && !flush;
         m_pop = !flush && (m_q.size() != 0) && !rs_full;
         if ((m_q.size() != 0) && rs_full) m_stall++;
         m_en = m_pop;
         if (flush) begin
            m_q.delete();
         end else begin
            if (m_pop) begin
               m_last = m_q.pop_front();
               exp_q.push_back(m_last);
               m_issued++;
            end
            if (m_acc) begin
               if (in_unit > UNIT_MV) m_err = 1'b1;
               else begin
                  m_new.unit   = in_unit;
                  m_new.reg1   = in_reg1;
                  m_new.reg2   = in_reg2;
                  m_new.reg3   = in_reg3;
                  m_new.hasimm = in_hasimm;
                  m_new.imm    = in_imm;
                  m_q.push_back(m_new);
               end
            end
         end
      end
   end

   // Monitor: consumes expected issues whenever the DUT strobes enable.
   issue_entry_t mon_e;
   always @(negedge clk) begin
      chk("enable", 64'(enable), 64'(m_en));
      if (enable) begin
         if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL issue_unexpected at %0t: got enable=1 expected no issue", $time);
         end else begin
            mon_e = exp_q.pop_front();
            chk("issue_unit", 64'(unit), 64'(mon_e.unit));
            chk("issue_reg1", 64'(reg1), 64'(mon_e.reg1));
            chk("issue_reg2", 64'(reg2), 64'(mon_e.reg2));
            chk("issue_reg3", 64'(reg3), 64'(mon_e.reg3));
            chk("issue_hasimm", 64'(hasimm), 64'(mon_e.hasimm));
            chk("issue_imm", 64'(imm), 64'(mon_e.imm));
         end
      end
      chk("hold_unit", 64'(unit), 64'(m_last.unit));
      chk("hold_imm", 64'(imm), 64'(m_last.imm));
      chk("count", 64'(count), 64'(m_q.size()));
      chk("in_ready", 64'(in_ready), 64'(m_q.size() != DEPTH));
      chk("err", 64'(err), 64'(m_err));
`ifdef ISSUE_STATS_EN
      chk("issued_cnt", 64'(issued_cnt), 64'(m_issued));
      chk("stall_cnt", 64'(stall_cnt), 64'(m_stall));
`endif
   end

   // Drive n cycles; percentages for valid/rs_full/flush/illegal; imm fixed to -5 when fix_imm.
   task automatic run(input int n, input int unsigned pv, input int unsigned pf,
                      input int unsigned pfl, input int unsigned pill, input bit fix_imm);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         in_valid  = ($urandom_range(99) < pv);
         rs_full   = ($urandom_range(99) < pf);
         flush     = ($urandom_range(99) < pfl);
         in_unit   = ($urandom_range(99) < pill) ? UNIT_W'($urandom_range(7, 5))
                                                 : UNIT_W'($urandom_range(4));
         in_reg1   = REG_W'($urandom);
         in_reg2   = REG_W'($urandom);
         in_reg3   = REG_W'($urandom);
         in_hasimm = 1'($urandom);
         in_imm    = fix_imm ? WORD_W'(-5) : WORD_W'($urandom);
      end
   endtask

   task automatic drive_one(input bit v, input bit f, input bit fl, input logic [UNIT_W-1:0] u,
                            input int unsigned r1, input int unsigned r2, input int unsigned r3);
      @(negedge clk);
      in_valid = v; rs_full = f; flush = fl; in_unit = u;
      in_reg1 = REG_W'(r1); in_reg2 = REG_W'(r2); in_reg3 = REG_W'(r3);
      in_hasimm = 1'b0; in_imm = '0;
   endtask

   initial begin
      repeat (2) @(negedge clk);
      rst = 1'b0;
      // Single add, then idle
      drive_one(1, 0, 0, UNIT_ADD, 1, 2, 3);
      repeat (4) drive_one(0, 0, 0, UNIT_LW, 0, 0, 0);
      // Back-pressure: fill past DEPTH while RS full, then release
      run(6, 100, 100, 0, 0, 0);
      run(8, 0, 0, 0, 0, 0);
      // Illegal opcode followed by a legal lw
      drive_one(1, 0, 0, UNIT_W'(5), 4, 5, 6);
      drive_one(1, 0, 0, UNIT_LW, 7, 8, 9);
      repeat (3) drive_one(0, 0, 0, UNIT_LW, 0, 0, 0);
      // Flush together with a push while three are queued
      run(3, 100, 100, 0, 0, 0);
      drive_one(1, 1, 1, UNIT_W'(6), 1, 1, 1);
      repeat (3) drive_one(0, 0, 0, UNIT_LW, 0, 0, 0);
      // Full-rate stream with negative immediate
      run(16, 100, 0, 0, 0, 1);
      run(3, 0, 0, 0, 0, 0);
      // Mixed random traffic
      run(150, 60, 30, 3, 10, 0);
      run(150, 90, 60, 1, 5, 0);
      run(100, 70, 10, 5, 20, 1);
      // Async reset with two entries queued
      run(2, 100, 100, 0, 0, 0);
      @(negedge clk);
      in_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("rst_enable", 64'(enable), 64'd0);
      chk("rst_count", 64'(count), 64'd0);
      chk("rst_unit", 64'(unit), 64'd0);
      chk("rst_err", 64'(err), 64'd0);
`ifdef ISSUE_STATS_EN
      chk("rst_issued_cnt", 64'(issued_cnt), 64'd0);
      chk("rst_stall_cnt", 64'(stall_cnt), 64'd0);
`endif
      @(negedge clk);
      rst = 1'b0;
      run(40, 60, 30, 2, 10, 0);
      run(8, 0, 0, 0, 0, 0);
      @(negedge clk);
      chk("drained", 64'(exp_q.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/issue_unit.md
# issue_unit

Front-end issue stage for the bourgeois out-of-order core. It buffers decoded instructions in a small in-order queue and drives the reservation station's instruction-entry port with one-cycle `enable` pulses. It is the sending end of the RS issue interface: it produces `unit`, `reg1`, `reg2`, `reg3`, `hasimm`, `imm` and `enable`, and honours the RS back-pressure output. It sits between the decoder and `RS`.

## Interface
- DEPTH, 4, queue entries; power of two, at least 2
- clk  in  1  core clock, all state on posedge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  decoder offers an instruction
- in_ready  out  1  queue can accept; equals count != DEPTH
- in_unit  in  3  000 lw, 001 sw, 010 add, 011 mul, 100 mv; 101–111 illegal
- in_reg1, in_reg2, in_reg3  in  `REG_SIZE each  register specifiers
- in_hasimm  in  1  immediate present
- in_imm  in  `WORD_SIZE signed  immediate
- rs_full  in  1  RS cannot accept this cycle; driven by RS `out`
- flush  in  1  discard all queued instructions
- unit  out  3  to RS
- reg1, reg2, reg3  out  `REG_SIZE each  to RS
- hasimm  out  1  to RS
- imm  out  `WORD_SIZE signed  to RS
- enable  out  1  one-cycle strobe: RS captures the fields this cycle
- count  out  $clog2(DEPTH+1)  occupied entries
- err  out  1  sticky: an illegal unit code was offered

## Operation
- **Push:** occurs on a clock edge when in_valid && in_ready && !flush. A legal in_unit writes the tail entry. An illegal in_unit (≥101) is dropped, sets err, and does not change count.
- **Pop:** occurs on a clock edge when count>0 && !rs_full && !flush. The head entry is loaded into the output registers, enable is set to 1, and the head advances.
- **Idle edge:** on any edge with no pop, enable goes to 0. unit, reg1, reg2, reg3, hasimm and imm hold their previous values.
- **Simultaneous push and pop:** both take effect on the same edge; count is unchanged. When full, in_ready is 0 even if a pop is pending. There is no pass-through.
- **Flush:** has priority over push and pop. Count goes to 0, the pointers reset, and enable goes to 0. err is kept.
- **Pointers:** log2(DEPTH) bits and wrap naturally; count saturates neither way by construction.
- **FSM (registered state):**
  - EMPTY: count==0.
  - ACTIVE: count>0 and the RS is accepting.
  - STALL: count>0 and rs_full was 1 at the last edge.
  - Transitions: EMPTY→ACTIVE on push. ACTIVE→STALL on rs_full. STALL→ACTIVE on !rs_full. Any state→EMPTY on the last pop or on flush.
  - State is observable only through count and enable. It is used by the stats counters.
- **Reset:** unit=000, reg1, reg2, reg3, imm all 0, hasimm=0, enable=0, count=0, err=0, state EMPTY, in_ready=1.

## Timing
- Outputs are registered; no combinational path runs from inputs to outputs except in_ready, which is derived from the count register.
- Minimum latency: an instruction pushed at edge N is presented with enable=1 after edge N+1.
- Sustained rate is one issue per cycle while rs_full=0 and the queue is non-empty.
- rs_full is sampled at the edge. If rs_full is raised in the cycle an instruction is presented, that instruction is already issued and is not re-sent.
- Asserting rst mid-stream drops all queued entries immediately, with no clock needed.

## Configuration
- ISSUE_STATS_EN:
  - **Defined:** adds outputs `issued_cnt` (32) and `stall_cnt` (32). issued_cnt increments on each pop. stall_cnt increments on each edge where count>0 and rs_full=1. Both reset to 0, wrap at 2^32, and are unaffected by flush.
  - **Undefined:** these ports and counters are absent.

## Structure
- Use the shared defines header for `REG_SIZE, `WORD_SIZE and `UNIT_SIZE.
- Add unit opcode constants UNIT_LW, UNIT_SW, UNIT_ADD, UNIT_MUL and UNIT_MV to the header for use by decoder, issue and RS.
- Put the queue storage and pointers in one sub-module, `issue_fifo`, parameterised by DEPTH and entry width. issue_unit holds the FSM, legality check, output registers and stats.

## Test plan
- **Single issue:** after reset, push add (unit 010, reg 1/2/3, imm 0). Expect enable=1 exactly one cycle after the next edge, with unit=010 and reg1=1; count returns to 0.
- **Back-pressure:** hold rs_full=1 and push 4 entries. Expect in_ready=0, count=4, enable never 1. Release rs_full. Expect 4 consecutive enable pulses in push order.
- **Illegal opcode:** push unit=101 and then a legal lw. Expect err=1 sticky, only the lw issued, count never above 1.
- **Flush with push:** with 3 queued and rs_full=1, assert flush together with in_valid for one edge. Expect count=0, no issue, err unchanged.
- **Stream:** push and pop every cycle with rs_full=0 over 16 instructions with imm=-5. Expect an exact in-order stream, imm=-5 sign-preserved, count steady at 1.
- **Reset mid-stream:** raise rst asynchronously with 2 queued. Expect immediate enable=0, count=0, unit=000. With ISSUE_STATS_EN defined, expect counters reset to 0.
